// File: rtl/router_sequencer.sv
// router_sequencer: steps one router instance through Init, routing-table
// load and the LoadStaging/Phase0/Phase1 network-cycle loop until the
// router stays quiescent long enough or the cycle limit is reached.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start, op=NOP
// INIT    | op=Init carrying the configuration word
// LOAD_RT | rt_ready high; each accepted entry becomes one LoadRt op
// STAGE   | op=LoadStaging
// PH0     | op=Phase0; router_done sampled on exit as done0
// PH1     | op=Phase1; quiescence / limit decision on exit
// HOLD    | op=NOP until hold drops, then back to STAGE
module router_sequencer #(
    parameter int OP_W         = 3,
    parameter int DATA_W       = 32,
    parameter int CYC_W        = 16,
    parameter int QUIET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_word,
    input  logic              rt_en,
    input  logic              rt_valid,
    output logic              rt_ready,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              rt_last,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic              hold,
    input  logic              inj_pending,
    input  logic              router_done,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] data,
    output logic [CYC_W-1:0]  in_cycle,
    output logic              busy,
    output logic              finished,
    output logic              timeout
);

    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STAGE  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_PH0    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_PH1    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LOADRT = OP_W'(4);
    localparam logic [OP_W-1:0] OP_INIT   = OP_W'(5);

    localparam int             QW   = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0]  QMAX = QW'(QUIET_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD_RT, S_STAGE, S_PH0, S_PH1, S_HOLD
    } state_t;

    state_t             r_state;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_data;
    logic [CYC_W-1:0]   r_cyc;
    logic [CYC_W-1:0]   r_max;
    logic [QW-1:0]      r_qcnt;
    logic               r_rt_ready;
    logic               r_busy;
    logic               r_finished;
    logic               r_timeout;
    logic               r_rt_en;
    logic               r_rt_fin;
    logic               r_done0;

    logic               w_quiet;
    logic               w_hs;
    logic               w_limit;
    logic [CYC_W-1:0]   w_cyc_inc;
    logic [QW-1:0]      w_qnext;

    // Next-cycle helpers for the PH1 decision and the rt handshake
    always_comb begin
        w_quiet   = r_done0 & router_done & ~inj_pending;
        w_hs      = rt_valid & r_rt_ready;
        w_cyc_inc = r_cyc + CYC_W'(1);
        w_limit   = (r_max != '0) && (w_cyc_inc == r_max);
        w_qnext   = '0;
        if (w_quiet) begin
            w_qnext = (r_qcnt == QMAX) ? QMAX : r_qcnt + QW'(1);
        end
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_data     <= '0;
            r_cyc      <= '0;
            r_max      <= '0;
            r_qcnt     <= '0;
            r_rt_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
            r_rt_en    <= 1'b0;
            r_rt_fin   <= 1'b0;
            r_done0    <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_INIT;
                        r_op      <= OP_INIT;
                        r_data    <= cfg_word;
                        r_rt_en   <= rt_en;
                        r_max     <= max_cycles;
                        r_cyc     <= '0;
                        r_qcnt    <= '0;
                        r_timeout <= 1'b0;
                        r_rt_fin  <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (r_rt_en) begin
                        r_state    <= S_LOAD_RT;
                        r_op       <= OP_NOP;
                        r_rt_ready <= 1'b1;
                    end else begin
                        r_state <= S_STAGE;
                        r_op    <= OP_STAGE;
                    end
                end
                S_LOAD_RT: begin
                    // r_rt_fin marks the LoadRt cycle of the final entry
                    if (r_rt_fin) begin
                        r_state <= S_STAGE;
                        r_op    <= OP_STAGE;
                    end else if (w_hs) begin
                        r_op   <= OP_LOADRT;
                        r_data <= rt_data;
                        if (rt_last) begin
                            r_rt_fin   <= 1'b1;
                            r_rt_ready <= 1'b0;
                        end
                    end else begin
                        r_op <= OP_NOP;
                    end
                end
                S_STAGE: begin
                    r_state <= S_PH0;
                    r_op    <= OP_PH0;
                end
                S_PH0: begin
                    r_done0 <= router_done;
                    r_state <= S_PH1;
                    r_op    <= OP_PH1;
                end
                S_PH1: begin
                    r_qcnt <= w_qnext;
                    if (w_qnext == QMAX) begin
                        r_state    <= S_IDLE;
                        r_op       <= OP_NOP;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else if (w_limit) begin
                        r_state    <= S_IDLE;
                        r_op       <= OP_NOP;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cyc <= w_cyc_inc;
                        if (hold) begin
                            r_state <= S_HOLD;
                            r_op    <= OP_NOP;
                        end else begin
                            r_state <= S_STAGE;
                            r_op    <= OP_STAGE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        r_state <= S_STAGE;
                        r_op    <= OP_STAGE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_op       <= OP_NOP;
                    r_busy     <= 1'b0;
                    r_rt_ready <= 1'b0;
                end
            endcase
        end
    end

    assign op       = r_op;
    assign data     = r_data;
    assign in_cycle = r_cyc;
    assign rt_ready = r_rt_ready;
    assign busy     = r_busy;
    assign finished = r_finished;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_router_sequencer.sv
// Testbench for router_sequencer: expected op/finished events are queued
// with their clock offset from the Init cycle; a monitor pops and compares
// every non-NOP op and every finished pulse.
module tb_router_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, rt_en, rt_valid, rt_last, hold, router_done, inj_pending;
    logic [31:0] cfg_word, rt_data, data;
    logic [15:0] max_cycles, in_cycle;
    logic        rt_ready, busy, finished, timeout;
    logic [2:0]  op;

    // simple router model: done once the network cycle reaches quiet_from
    logic [15:0] quiet_from;
    logic        inj_en;
    logic [15:0] inj_cyc;
    assign router_done = (in_cycle >= quiet_from);
    assign inj_pending = inj_en && (in_cycle == inj_cyc);

    router_sequencer #(.OP_W(3), .DATA_W(32), .CYC_W(16), .QUIET_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .rt_en(rt_en),
        .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_data(rt_data), .rt_last(rt_last),
        .max_cycles(max_cycles), .hold(hold), .inj_pending(inj_pending),
        .router_done(router_done), .op(op), .data(data), .in_cycle(in_cycle),
        .busy(busy), .finished(finished), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rel;
        logic [2:0]  op;
        logic [31:0] data;
        logic [15:0] cyc;
        logic        fin;
        logic        to;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  clk_n = 0;
    int  t0 = 0;

    always @(posedge clk) clk_n <= clk_n + 1;

    // Monitor: every visible operation or finish pulse consumes one expectation
    always @(negedge clk) begin
        ev_t e;
        if (op != 3'd0 || finished) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event rel=%0d op=%0d data=%h cyc=%0d fin=%0d to=%0d",
                         clk_n - t0, op, data, in_cycle, finished, timeout);
            end else begin
                e = exp_q.pop_front();
                if (e.rel != clk_n - t0 || e.op !== op || e.data !== data ||
                    e.cyc !== in_cycle || e.fin !== finished || e.to !== timeout) begin
                    miscompares++;
                    $display("FAIL event got rel=%0d op=%0d data=%h cyc=%0d fin=%0d to=%0d; exp rel=%0d op=%0d data=%h cyc=%0d fin=%0d to=%0d",
                             clk_n - t0, op, data, in_cycle, finished, timeout,
                             e.rel, e.op, e.data, e.cyc, e.fin, e.to);
                end
            end
        end
    end

    task automatic push(input int rel, input int o, input logic [31:0] d,
                        input int cyc, input logic fin, input logic to);
        ev_t e;
        e.rel = rel; e.op = 3'(o); e.data = d; e.cyc = 16'(cyc); e.fin = fin; e.to = to;
        exp_q.push_back(e);
    endtask

    // LoadStaging/Phase0/Phase1 of network cycle k, LoadStaging at base+3k
    task automatic push_cyc(input int k, input int base, input logic [31:0] d);
        push(base + 3*k,     1, d, k, 1'b0, 1'b0);
        push(base + 3*k + 1, 2, d, k, 1'b0, 1'b0);
        push(base + 3*k + 2, 3, d, k, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Returns at the negedge of the Init cycle (rel 0)
    task automatic start_run(input logic [31:0] cfg, input logic ren, input logic [15:0] mx);
        @(negedge clk);
        start = 1'b1; cfg_word = cfg; rt_en = ren; max_cycles = mx;
        t0 = clk_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic exp_to);
        for (int i = 0; i < 120 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        chk("busy_after", 32'(busy), 32'(1'b0));
        chk("timeout_after", 32'(timeout), 32'(exp_to));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rt_en = 1'b0; rt_valid = 1'b0; rt_last = 1'b0;
        rt_data = '0; cfg_word = '0; max_cycles = '0; hold = 1'b0;
        quiet_from = 16'd0; inj_en = 1'b0; inj_cyc = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_cycle", 32'(in_cycle), 32'd0);
        chk("rst_rt_ready", 32'(rt_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: minimal run, quiet from cycle 0
        push(0, 5, 32'h1, 0, 0, 0);
        push_cyc(0, 1, 32'h1);
        push_cyc(1, 1, 32'h1);
        push(7, 0, 32'h1, 1, 1, 0);
        start_run(32'h0000_0001, 1'b0, 16'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(1'b0);

        // T2: routing-table load with a valid bubble
        push(0, 5, 32'hA5A5_0002, 0, 0, 0);
        push(2, 4, 32'h0000_400C, 0, 0, 0);
        push(4, 4, 32'h0000_8005, 0, 0, 0);
        push(5, 4, 32'h0000_C007, 0, 0, 0);
        push_cyc(0, 6, 32'h0000_C007);
        push_cyc(1, 6, 32'h0000_C007);
        push(12, 0, 32'h0000_C007, 1, 1, 0);
        start_run(32'hA5A5_0002, 1'b1, 16'd0);
        @(negedge clk);
        chk("t2_ready_r1", 32'(rt_ready), 32'd1);
        rt_valid = 1'b1; rt_data = 32'h0000_400C;
        @(negedge clk);
        rt_valid = 1'b0;
        @(negedge clk);
        rt_valid = 1'b1; rt_data = 32'h0000_8005;
        @(negedge clk);
        rt_valid = 1'b1; rt_data = 32'h0000_C007; rt_last = 1'b1;
        @(negedge clk);
        rt_valid = 1'b0; rt_last = 1'b0;
        chk("t2_ready_r5", 32'(rt_ready), 32'd0);
        wait_done(1'b0);

        // T3: quiet from cycle 5, unlimited; a start while busy is ignored
        quiet_from = 16'd5;
        push(0, 5, 32'h3, 0, 0, 0);
        for (int k = 0; k <= 6; k++) push_cyc(k, 1, 32'h3);
        push(22, 0, 32'h3, 6, 1, 0);
        start_run(32'h0000_0003, 1'b0, 16'd0);
        repeat (10) @(negedge clk);
        start = 1'b1; cfg_word = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);

        // T4: never quiet, limit 4 cycles
        quiet_from = 16'hFFFF;
        push(0, 5, 32'h4, 0, 0, 0);
        for (int k = 0; k <= 3; k++) push_cyc(k, 1, 32'h4);
        push(13, 0, 32'h4, 3, 1, 1);
        start_run(32'h0000_0004, 1'b0, 16'd4);
        wait_done(1'b1);
        chk("t4_timeout_sticky", 32'(timeout), 32'd1);

        // T5: inj_pending in cycle 1 resets the quiet count; hold 5 clocks after cycle 1
        quiet_from = 16'd0; inj_en = 1'b1; inj_cyc = 16'd1;
        push(0, 5, 32'h5, 0, 0, 0);
        push_cyc(0, 1, 32'h5);
        push_cyc(1, 1, 32'h5);
        push_cyc(2, 6, 32'h5);
        push_cyc(3, 6, 32'h5);
        push(18, 0, 32'h5, 3, 1, 0);
        start_run(32'h0000_0005, 1'b0, 16'd0);
        chk("t5_timeout_clr", 32'(timeout), 32'd0);
        repeat (6) @(negedge clk);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_hold_op", 32'(op), 32'd0);
        chk("t5_hold_busy", 32'(busy), 32'd1);
        chk("t5_hold_cycle", 32'(in_cycle), 32'd2);
        repeat (2) @(negedge clk);
        hold = 1'b0;
        wait_done(1'b0);
        inj_en = 1'b0;

        // T6: reset during PH0, then a fresh run replays Init
        quiet_from = 16'hFFFF;
        push(0, 5, 32'h6, 0, 0, 0);
        push(1, 1, 32'h6, 0, 0, 0);
        push(2, 2, 32'h6, 0, 0, 0);
        start_run(32'h0000_0006, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_op", 32'(op), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cycle", 32'(in_cycle), 32'd0);
        chk("t6_rst_data", data, 32'd0);
        rst = 1'b0;
        wait_done(1'b0);
        quiet_from = 16'd0;
        push(0, 5, 32'h7, 0, 0, 0);
        push_cyc(0, 1, 32'h7);
        push_cyc(1, 1, 32'h7);
        push(7, 0, 32'h7, 1, 1, 0);
        start_run(32'h0000_0007, 1'b0, 16'd0);
        wait_done(1'b0);

        // T7: quiescence and limit coincide at cycle 1; quiescence wins
        push(0, 5, 32'h8, 0, 0, 0);
        push_cyc(0, 1, 32'h8);
        push_cyc(1, 1, 32'h8);
        push(7, 0, 32'h8, 1, 1, 0);
        start_run(32'h0000_0008, 1'b0, 16'd2);
        wait_done(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
